// File: rtl/iq_dispatch_fifo.sv
// Circular instruction queue that dispatches its head, in order, to one of
// NUM_RS reservation stations and allocates a ROB tag for it.
module iq_dispatch_fifo #(
    parameter int DEPTH  = 8,
    parameter int IW     = 32,
    parameter int NUM_RS = 4,
    parameter int TAG_W  = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [IW-1:0]               in_instr,
    input  logic [31:0]                 in_pc,
    input  logic [$clog2(NUM_RS)-1:0]   in_rs_sel,
    input  logic                        in_serial,
    input  logic [NUM_RS-1:0]           rs_empty,
    input  logic                        rob_full,
    input  logic                        rob_empty,
    input  logic                        flush,
    input  logic [TAG_W-1:0]            flush_tag,
    output logic [NUM_RS-1:0]           rs_load,
    output logic                        rob_load,
    output logic [IW-1:0]               out_instr,
    output logic [31:0]                 out_pc,
    output logic [TAG_W-1:0]            out_tag,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int SEL_W = $clog2(NUM_RS);
    localparam int CNT_W = PTR_W + 1;

    logic [IW-1:0]    instr_mem  [DEPTH];
    logic [31:0]      pc_mem     [DEPTH];
    logic [SEL_W-1:0] sel_mem    [DEPTH];
    logic [DEPTH-1:0] serial_mem;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count_q;
    logic [TAG_W-1:0] tag_q;

    logic             full;
    logic             empty;
    logic             enq;
    logic             deq;
    logic [SEL_W-1:0] head_sel;
    logic             head_serial;
    logic             head_rs_free;

    assign full        = (count_q == CNT_W'(DEPTH));
    assign empty       = (count_q == '0);
    assign head_sel    = sel_mem[head];
    assign head_serial = serial_mem[head];

    // in_ready is held high through reset so the port reads sane before the
    // occupancy register has been initialised; rst still blocks the write.
    assign in_ready = rst | ~full;
    assign enq      = in_valid & in_ready & ~flush & ~rst;

    // A select value with no matching station leaves head_rs_free low, so an
    // out-of-range entry simply never dispatches.
    always_comb begin
        head_rs_free = 1'b0;
        for (int i = 0; i < NUM_RS; i++) begin
            if (head_sel == SEL_W'(i)) begin
                head_rs_free = rs_empty[i];
            end
        end
    end

    assign deq = ~rst & ~empty & ~flush & head_rs_free & ~rob_full
               & (~head_serial | rob_empty);

    always_comb begin
        rs_load = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            rs_load[i] = deq & (head_sel == SEL_W'(i));
        end
    end

    assign rob_load  = |rs_load;
    assign out_tag   = tag_q;
    assign count     = count_q;
    assign out_instr = (rst | empty) ? '0 : instr_mem[head];
    assign out_pc    = (rst | empty) ? '0 : pc_mem[head];

    always_ff @(posedge clk) begin
        if (enq) begin
            instr_mem[tail]  <= in_instr;
            pc_mem[tail]     <= in_pc;
            sel_mem[tail]    <= in_rs_sel;
            serial_mem[tail] <= in_serial;
        end
    end

    // Flush rewinds both pointers and reloads the tag counter from the
    // recovery tag; reset outranks it.
    always_ff @(posedge clk) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            tag_q   <= '0;
        end else if (flush) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            tag_q   <= flush_tag;
        end else begin
            if (enq) begin
                tail <= tail + PTR_W'(1);
            end
            if (deq) begin
                head  <= head + PTR_W'(1);
                tag_q <= tag_q + TAG_W'(1);
            end
            unique case ({enq, deq})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_iq_dispatch_fifo.sv
// Directed bench for iq_dispatch_fifo with a queue-based reference model
// predicting dispatch strobes, tags, head contents and occupancy.
module tb_iq_dispatch_fifo;

    localparam int DEPTH  = 8;
    localparam int IW     = 32;
    localparam int NUM_RS = 4;
    localparam int TAG_W  = 3;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [IW-1:0]     in_instr;
    logic [31:0]       in_pc;
    logic [1:0]        in_rs_sel;
    logic              in_serial;
    logic [NUM_RS-1:0] rs_empty;
    logic              rob_full;
    logic              rob_empty;
    logic              flush;
    logic [TAG_W-1:0]  flush_tag;
    logic [NUM_RS-1:0] rs_load;
    logic              rob_load;
    logic [IW-1:0]     out_instr;
    logic [31:0]       out_pc;
    logic [TAG_W-1:0]  out_tag;
    logic [3:0]        count;

    typedef struct {
        logic [IW-1:0] instr;
        logic [31:0]   pc;
        logic [1:0]    sel;
        logic          serial;
    } entry_t;

    entry_t           sb[$];
    logic [TAG_W-1:0] model_tag;
    int               checks;
    int               errors;

    iq_dispatch_fifo #(
        .DEPTH(DEPTH), .IW(IW), .NUM_RS(NUM_RS), .TAG_W(TAG_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_pc(in_pc), .in_rs_sel(in_rs_sel), .in_serial(in_serial),
        .rs_empty(rs_empty), .rob_full(rob_full), .rob_empty(rob_empty),
        .flush(flush), .flush_tag(flush_tag),
        .rs_load(rs_load), .rob_load(rob_load), .out_instr(out_instr),
        .out_pc(out_pc), .out_tag(out_tag), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic valid, input logic [IW-1:0] instr,
                                  input logic [31:0] pc, input logic [1:0] sel,
                                  input logic serial);
        in_valid  = valid;
        in_instr  = instr;
        in_pc     = pc;
        in_rs_sel = sel;
        in_serial = serial;
    endtask

    // Compare outputs against the model, then advance the model to the
    // state it should hold after the coming rising edge.
    task automatic check_output();
        logic       disp;
        logic       was_full;
        logic [3:0] exp_load;
        entry_t     e;
        disp     = 1'b0;
        exp_load = '0;
        if (rst) begin
            check("rst_rs_load", rs_load, 0);
            check("rst_rob_load", rob_load, 0);
            check("rst_in_ready", in_ready, 1);
            check("rst_out_instr", out_instr, 0);
            check("rst_out_pc", out_pc, 0);
        end else begin
            if (sb.size() > 0) begin
                disp = !flush && rs_empty[sb[0].sel] && !rob_full
                       && (!sb[0].serial || rob_empty);
            end
            if (disp) exp_load = 4'b0001 << sb[0].sel;
            check("rs_load", rs_load, exp_load);
            check("rob_load", rob_load, disp);
            check("count", count, sb.size());
            check("in_ready", in_ready, sb.size() != DEPTH);
            if (sb.size() > 0) begin
                check("out_instr", out_instr, sb[0].instr);
                check("out_pc", out_pc, sb[0].pc);
            end else begin
                check("empty_out_instr", out_instr, 0);
                check("empty_out_pc", out_pc, 0);
            end
            if (disp) check("out_tag", out_tag, model_tag);
        end

        if (rst) begin
            sb.delete();
            model_tag = '0;
        end else if (flush) begin
            sb.delete();
            model_tag = flush_tag;
        end else begin
            was_full = (sb.size() == DEPTH);
            if (disp) begin
                void'(sb.pop_front());
                model_tag++;
            end
            if (in_valid && !was_full) begin
                e.instr  = in_instr;
                e.pc     = in_pc;
                e.sel    = in_rs_sel;
                e.serial = in_serial;
                sb.push_back(e);
            end
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check_output();
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        model_tag = '0;
        rst       = 1'b1;
        rs_empty  = 4'hF;
        rob_full  = 1'b0;
        rob_empty = 1'b1;
        flush     = 1'b0;
        flush_tag = '0;
        apply_stimulus(0, '0, '0, 2'd0, 0);
        tick(2);
        rst = 1'b0;

        // Three entries to RS 0,1,2 with every station free.
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1, 32'h1000 + i, 32'h60 + 4 * i, 2'(i), 0);
            tick(1);
        end
        apply_stimulus(0, '0, '0, 2'd0, 0);
        tick(4);
        check("basic_drain_count", count, 0);

        // Fill with all stations busy, keep pushing past full.
        rs_empty = 4'h0;
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1, 32'h2000 + i, 32'h100 + 4 * i, 2'(i % 4), 0);
            tick(1);
        end
        check("fill_count", count, 8);
        check("fill_ready", in_ready, 0);

        // Release the stations while in_valid stays high; tail wraps.
        rs_empty = 4'hF;
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1, 32'h3000 + i, 32'h200 + 4 * i, 2'((i + 1) % 4), 0);
            tick(1);
        end
        apply_stimulus(0, '0, '0, 2'd0, 0);
        tick(10);

        // Head blocked on RS 2 holds back a younger RS 0 entry.
        rs_empty = 4'b1011;
        apply_stimulus(1, 32'h4000, 32'h300, 2'd2, 0);
        tick(1);
        apply_stimulus(1, 32'h4001, 32'h304, 2'd0, 0);
        tick(1);
        apply_stimulus(0, '0, '0, 2'd0, 0);
        tick(5);
        check("stall_count", count, 2);
        rs_empty = 4'hF;
        tick(4);

        // Serialising entry waits for an empty ROB.
        rob_empty = 1'b0;
        apply_stimulus(1, 32'h5000, 32'h400, 2'd1, 1);
        tick(1);
        apply_stimulus(0, '0, '0, 2'd0, 0);
        tick(4);
        check("serial_hold_count", count, 1);
        rob_empty = 1'b1;
        tick(3);

        // Bring the tag to 6, queue 5 entries, then flush to tag 3.
        flush     = 1'b1;
        flush_tag = 3'd1;
        tick(1);
        flush = 1'b0;
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1, 32'h6000 + i, 32'h500 + 4 * i, 2'(i % 4), 0);
            tick(1);
        end
        apply_stimulus(0, '0, '0, 2'd0, 0);
        tick(3);
        rs_empty = 4'h0;
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1, 32'h6100 + i, 32'h600 + 4 * i, 2'(i % 4), 0);
            tick(1);
        end
        check("preflush_count", count, 5);
        check("preflush_tag", out_tag, 6);
        flush     = 1'b1;
        flush_tag = 3'd3;
        apply_stimulus(1, 32'h7777, 32'h777, 2'd0, 0);
        tick(1);
        flush = 1'b0;
        apply_stimulus(0, '0, '0, 2'd0, 0);
        check("flush_count", count, 0);
        check("flush_tag", out_tag, 3);
        tick(1);
        rs_empty = 4'hF;
        apply_stimulus(1, 32'h7800, 32'h780, 2'd3, 0);
        tick(1);
        apply_stimulus(0, '0, '0, 2'd0, 0);
        tick(3);

        // Nine dispatches from reset: tags 0..7 then wrap to 0.
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            apply_stimulus(1, 32'h8000 + i, 32'h800 + 4 * i, 2'(i % 4), 0);
            tick(1);
        end
        apply_stimulus(0, '0, '0, 2'd0, 0);
        tick(3);
        check("wrap_tag", out_tag, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iq_dispatch_fifo.md
Name: iq_dispatch_fifo

Overview:
- Parametrised successor to the single-depth instruction queue in the Tomasulo front end.
- Buffers fetched, pre-decoded instructions in a circular FIFO and dispatches the head, in order, to one of NUM_RS reservation stations while allocating a ROB entry and tag.
- Adds branch-flush recovery and serialising (fence-style) instructions that wait for an empty ROB.

Parameters:
- DEPTH, 8, queue entries; power of two, >= 2.
- IW, 32, instruction word width.
- NUM_RS, 4, number of reservation stations (for example res1..res4); >= 2.
- TAG_W, 3, ROB tag width; ROB has 2^TAG_W entries.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  enqueue request
- in_ready  out  1  queue can accept; equals !full
- in_instr  in  IW  instruction word
- in_pc  in  32  instruction PC
- in_rs_sel  in  $clog2(NUM_RS)  target reservation station index
- in_serial  in  1  serialising instruction
- rs_empty  in  NUM_RS  bit i = RS i has a free slot
- rob_full  in  1  ROB cannot allocate
- rob_empty  in  1  ROB holds no uncommitted entries
- flush  in  1  branch mispredict; discard all queued entries
- flush_tag  in  TAG_W  next ROB tag to allocate after the flush
- rs_load  out  NUM_RS  one-hot dispatch strobe
- rob_load  out  1  ROB allocate strobe; equals |rs_load
- out_instr  out  IW  head instruction
- out_pc  out  32  head PC
- out_tag  out  TAG_W  ROB tag given to the dispatched instruction
- count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Storage: registered array of DEPTH entries, each holding {instr, pc, rs_sel, serial}.
- Pointers: head and tail are $clog2(DEPTH) bits and wrap modulo DEPTH. count goes 0..DEPTH; full = (count == DEPTH); empty = (count == 0).
- Reset (rst high at posedge): head = tail = 0, count = 0, tag counter = 0. Array contents are don't-care.
- Outputs during the reset cycle and after it: rs_load = 0, rob_load = 0, in_ready = 1, out_* = 0 while empty.
- Enqueue: happens at posedge when in_valid && in_ready && !flush. The entry is written at tail, then tail++.
- in_ready is !full only. It does not look ahead to a same-cycle dispatch, so the full queue accepts nothing in that cycle even if it dispatches.
- Dispatch condition (combinational): !empty && !flush && rs_empty[head.rs_sel] && !rob_full && (!head.serial || rob_empty).
- When the dispatch condition holds:
  - rs_load[head.rs_sel] = 1 and rob_load = 1 in that cycle.
  - out_tag = tag counter.
  - At posedge: head++ and the tag counter increments, wrapping modulo 2^TAG_W.
- When the dispatch condition does not hold, rs_load = 0.
- out_instr and out_pc always show the head entry and are 0 when empty.
- Latency: an entry enqueued at edge N can dispatch in the cycle after edge N at the earliest. There is no empty-queue bypass.
- Simultaneous enqueue and dispatch (not full): count is unchanged and both pointers advance.
- Strict in-order dispatch: a stalled head blocks all younger entries, even if their RS is free.
- Serialising entry: holds at the head until rob_empty = 1 and its other conditions hold. After it dispatches, normal flow resumes.
- Flush: at posedge with flush = 1:
  - head = tail = 0, count = 0, tag counter = flush_tag.
  - No enqueue or dispatch occurs in that cycle; flush has priority over both.
  - rs_load = 0 combinationally during the flush cycle.
- rst has priority over flush.
- Out-of-range in_rs_sel (>= NUM_RS): the entry is enqueued but never dispatches. Drivers must avoid this.

Test Plan:
- Reset, then enqueue 3 entries (pc 0x60, 0x64, 0x68; rs_sel 0, 1, 2) with all rs_empty = 1 → rs_load one-hot 0001, 0010, 0100 on consecutive cycles with out_tag 0, 1, 2; count ends at 0.
- Fill with rs_empty = 0 → in_ready drops after the 8th enqueue and count = 8. Then set rs_empty = 4'b1111 while in_valid is held → exactly one dispatch per cycle; the first new enqueue lands one cycle after the first dispatch; tail wraps to 0 correctly.
- Head targets RS 2 with rs_empty = 4'b1011, and the next entry targets RS 0 → no rs_load for 5 cycles. Set bit 2 → RS 2 dispatches, then RS 0.
- Serial entry at head with rob_empty = 0 for 4 cycles → rs_load = 0. rob_empty = 1 → dispatch with the next tag.
- 5 entries queued, tag = 6; assert flush with flush_tag = 3 while in_valid = 1 → count = 0, no rs_load, the enqueue is dropped; the next dispatched entry gets out_tag = 3.
- Dispatch 9 entries from reset → out_tag sequence 0..7, 0.
